bit4_down_timer: RTL and testbench



---
 rtl/bit4_down_timer.sv | 81 ++++++++
 tb/tb_bit4_down_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit4_down_timer.sv
// Loadable down-counter/timer with terminal-count pulse; runs one-shot or periodic.
// Meant to sit beside the 4-bit up counter in the same clock domain.
module bit4_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] reload_reg;
  logic             tc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
    end else if (load) begin
      // A load restarts the run from any state and masks a coincident terminal event.
      reload_reg <= load_val;
      count_reg  <= load_val;
      state_reg  <= RUN;
      tc_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tc_reg <= 1'b0;
        end
        RUN: begin
          if (!en) begin
            tc_reg <= 1'b0;
          end else if (count_reg == WIDTH'(1)) begin
            tc_reg <= 1'b1;
            if (auto_reload) begin
              count_reg <= reload_reg;
            end else begin
              count_reg <= '0;
              state_reg <= DONE;
            end
          end else begin
            // Wraps 0 -> all-ones, so a load value of 0 gives a full 2^WIDTH run.
            count_reg <= count_reg - WIDTH'(1);
            tc_reg    <= 1'b0;
          end
        end
        DONE: begin
          count_reg <= '0;
          tc_reg    <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
          tc_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_bit4_down_timer.sv
// Directed bench for bit4_down_timer: one-shot, periodic, full-range, gated enable,
// load collisions and asynchronous reset, with hand-derived expectations.
module tb_bit4_down_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  bit4_down_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
    .auto_reload(auto_reload), .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v, input logic ar);
    load = 1'b1; load_val = v; en = 1'b0; auto_reload = ar;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] want;
    reset = 1'b1; load = 1'b0; load_val = 4'd0; en = 1'b0; auto_reload = 1'b0;
    #1;
    want = {4'd0, 1'b0, 1'b0, 1'b0};
    total++;
    if ({count, tc, busy, done} !== want) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", {count, tc, busy, done}, want);
    end
    step(); step();
    total++;
    if ({count, tc, busy, done} !== want) begin
      bad++;
      $display("FAIL reset_held got=%h want=%h", {count, tc, busy, done}, want);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("reset: count=%0d tc=%b busy=%b done=%b", count, tc, busy, done);
  endtask

  task automatic test_oneshot();
    logic [6:0] want;
    do_load(4'd5, 1'b0);
    want = {4'd5, 1'b0, 1'b1, 1'b0};
    total++;
    if ({count, tc, busy, done} !== want) begin
      bad++;
      $display("FAIL oneshot_load got=%h want=%h", {count, tc, busy, done}, want);
    end
    en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      step();
      want = {4'(i), i == 0, i != 0, i == 0};
      $display("oneshot: count=%0d tc=%b busy=%b done=%b", count, tc, busy, done);
      total++;
      if ({count, tc, busy, done} !== want) begin
        bad++;
        $display("FAIL oneshot_run i=%0d got=%h want=%h", i, {count, tc, busy, done}, want);
      end
    end
    auto_reload = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      want = {4'd0, 1'b0, 1'b0, 1'b1};
      total++;
      if ({count, tc, busy, done} !== want) begin
        bad++;
        $display("FAIL oneshot_hold k=%0d got=%h want=%h", k, {count, tc, busy, done}, want);
      end
    end
  endtask

  task automatic test_periodic();
    logic [6:0] want;
    do_load(4'd3, 1'b1);
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      want = {((k % 3) == 0) ? 4'd3 : 4'(3 - (k % 3)), (k % 3) == 0, 1'b1, 1'b0};
      $display("periodic: k=%0d count=%0d tc=%b", k, count, tc);
      total++;
      if ({count, tc, busy, done} !== want) begin
        bad++;
        $display("FAIL periodic k=%0d got=%h want=%h", k, {count, tc, busy, done}, want);
      end
    end
  endtask

  task automatic test_period_one();
    logic [6:0] want;
    do_load(4'd1, 1'b1);
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      want = {4'd1, 1'b1, 1'b1, 1'b0};
      total++;
      if ({count, tc, busy, done} !== want) begin
        bad++;
        $display("FAIL period_one k=%0d got=%h want=%h", k, {count, tc, busy, done}, want);
      end
    end
    $display("period_one: count=%0d tc=%b", count, tc);
  endtask

  task automatic test_full_range();
    logic [6:0] want;
    do_load(4'd0, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      want = (k < 16) ? {4'(16 - k), 1'b0, 1'b1, 1'b0} : {4'd0, 1'b1, 1'b0, 1'b1};
      total++;
      if ({count, tc, busy, done} !== want) begin
        bad++;
        $display("FAIL full_range k=%0d got=%h want=%h", k, {count, tc, busy, done}, want);
      end
    end
    $display("full_range: count=%0d tc=%b done=%b", count, tc, done);
  endtask

  task automatic test_gated_enable();
    logic [6:0] want;
    int         e;
    do_load(4'd4, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      en = (k % 2) == 1;
      step();
      e = (k + 1) / 2;
      want = {4'(4 - e), k == 7, k < 7, k >= 7};
      $display("gated: k=%0d count=%0d tc=%b", k, count, tc);
      total++;
      if ({count, tc, busy, done} !== want) begin
        bad++;
        $display("FAIL gated k=%0d got=%h want=%h", k, {count, tc, busy, done}, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] want;
    do_load(4'd2, 1'b0);
    en = 1'b1;
    step();
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0;
    want = {4'd9, 1'b0, 1'b1, 1'b0};
    total++;
    if ({count, tc, busy, done} !== want) begin
      bad++;
      $display("FAIL load_on_terminal got=%h want=%h", {count, tc, busy, done}, want);
    end
    step();
    want = {4'd8, 1'b0, 1'b1, 1'b0};
    total++;
    if ({count, tc, busy, done} !== want) begin
      bad++;
      $display("FAIL after_collision got=%h want=%h", {count, tc, busy, done}, want);
    end
    do_load(4'd1, 1'b0);
    en = 1'b1;
    step();
    want = {4'd0, 1'b1, 1'b0, 1'b1};
    total++;
    if ({count, tc, busy, done} !== want) begin
      bad++;
      $display("FAIL reach_done got=%h want=%h", {count, tc, busy, done}, want);
    end
    load = 1'b1; load_val = 4'd7;
    step();
    load = 1'b0;
    want = {4'd7, 1'b0, 1'b1, 1'b0};
    total++;
    if ({count, tc, busy, done} !== want) begin
      bad++;
      $display("FAIL load_from_done got=%h want=%h", {count, tc, busy, done}, want);
    end
    $display("back_to_back: count=%0d busy=%b done=%b", count, busy, done);
  endtask

  task automatic test_reset_midrun();
    logic [6:0] want;
    do_load(4'd8, 1'b0);
    en = 1'b1;
    step(); step();
    want = {4'd6, 1'b0, 1'b1, 1'b0};
    total++;
    if ({count, tc, busy, done} !== want) begin
      bad++;
      $display("FAIL pre_reset got=%h want=%h", {count, tc, busy, done}, want);
    end
    #2 reset = 1'b1;
    #1;
    want = {4'd0, 1'b0, 1'b0, 1'b0};
    total++;
    if ({count, tc, busy, done} !== want) begin
      bad++;
      $display("FAIL reset_midrun got=%h want=%h", {count, tc, busy, done}, want);
    end
    @(negedge clk);
    reset = 1'b0; auto_reload = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if ({count, tc, busy, done} !== want) begin
        bad++;
        $display("FAIL idle_after_reset k=%0d got=%h want=%h", k, {count, tc, busy, done}, want);
      end
    end
    $display("reset_midrun: count=%0d busy=%b done=%b", count, busy, done);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_period_one();
    test_full_range();
    test_gated_enable();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
